// File: rtl/gpio_led_pkg.sv
// Shared definitions for the front-panel LED controller: channel mode
// encodings and counter sizing helpers.
package gpio_led_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_DIRECT  = 2'd0,
        MODE_ANY     = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } led_mode_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Counter width able to hold 0..value-1, never narrower than one bit.
    function automatic int unsigned counter_width(input int unsigned value);
        return (clog2(value) < 1) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch input: 2-flop synchroniser, stable-count debouncer, clean level
// and a one-cycle pulse on each accepted rising edge.
module sw_debounce
    import gpio_led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic SYSTEMCLOCK,
    input  logic reset,
    input  logic pin,
    output logic clean,
    output logic rise
);

    localparam int unsigned CNT_W = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic             clean_d;
    logic [CNT_W-1:0] count;

    always_ff @(posedge SYSTEMCLOCK) begin
        if (reset) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            clean   <= 1'b0;
            clean_d <= 1'b0;
            rise    <= 1'b0;
            count   <= '0;
        end else begin
            sync0   <= pin;
            sync1   <= sync0;
            clean_d <= clean;
            rise    <= clean & ~clean_d;
            // Count only while the synchronised level disagrees with the accepted one.
            if (sync1 == clean) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                clean <= sync1;
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/gpio_led_ctrl.sv
// Front-panel LED controller: debounced switches, shared blink timer,
// breathing PWM and a per-channel mode mux driving registered LED outputs.
module gpio_led_ctrl
    import gpio_led_pkg::*;
#(
    parameter int unsigned N_CH            = 4,
    parameter int unsigned N_SW            = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000,
    parameter int unsigned BLINK_HALF      = 50_000_000,
    parameter int unsigned PWM_BITS        = 8
) (
    input  logic                     SYSTEMCLOCK,
    input  logic                     reset,
    input  logic [N_SW-1:0]          gpio_switch,
    input  logic [MODE_W*N_CH-1:0]   mode,
    output logic [N_CH-1:0]          gpio_led,
    output logic [N_SW-1:0]          sw_clean,
    output logic [N_SW-1:0]          sw_rise
);

    localparam int unsigned BLINK_W = counter_width(BLINK_HALF);
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;

    logic [BLINK_W-1:0]  blink_cnt;
    logic                blink_phase;
    logic                blink_wrap_c;
    logic                blink_next_c;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] duty;
    logic                duty_down;
    logic                pwm_out_c;
    logic [N_CH-1:0]     led_next_c;

    for (genvar j = 0; j < N_SW; j++) begin : g_sw
        sw_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .SYSTEMCLOCK(SYSTEMCLOCK),
            .reset      (reset),
            .pin        (gpio_switch[j]),
            .clean      (sw_clean[j]),
            .rise       (sw_rise[j])
        );
    end

    // LEDs take the phase being entered so they toggle on the wrap cycle itself.
    assign blink_wrap_c = (blink_cnt == BLINK_LAST);
    assign blink_next_c = blink_phase ^ blink_wrap_c;

    always_ff @(posedge SYSTEMCLOCK) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            blink_cnt   <= blink_wrap_c ? '0 : blink_cnt + BLINK_W'(1);
            blink_phase <= blink_next_c;
        end
    end

    // Triangle ramp of duty, one step per PWM period, endpoints visited once.
    always_ff @(posedge SYSTEMCLOCK) begin
        if (reset) begin
            pwm_cnt   <= '0;
            duty      <= '0;
            duty_down <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == PWM_MAX) begin
                if (duty_down) begin
                    duty <= duty - PWM_BITS'(1);
                    if (duty == PWM_BITS'(1)) begin
                        duty_down <= 1'b0;
                    end
                end else begin
                    duty <= duty + PWM_BITS'(1);
                    if (duty == PWM_MAX - PWM_BITS'(1)) begin
                        duty_down <= 1'b1;
                    end
                end
            end
        end
    end

    assign pwm_out_c = (pwm_cnt < duty);

    always_comb begin
        led_next_c = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (mode[MODE_W*i +: MODE_W])
                MODE_DIRECT:  led_next_c[i] = sw_clean[i % N_SW];
                MODE_ANY:     led_next_c[i] = |sw_clean;
                MODE_BLINK:   led_next_c[i] = blink_next_c;
                MODE_BREATHE: led_next_c[i] = pwm_out_c;
                default:      led_next_c[i] = 1'b0;
            endcase
        end
    end

    // Reset drives every LED on as a lamp test.
    always_ff @(posedge SYSTEMCLOCK) begin
        if (reset) begin
            gpio_led <= '1;
        end else begin
            gpio_led <= led_next_c;
        end
    end

endmodule

// File: tb/tb_gpio_led_ctrl.sv
// Scoreboard bench for gpio_led_ctrl: a cycle-level reference model pushes
// expected outputs, a negedge monitor pops and compares.
module tb_gpio_led_ctrl;

    localparam int unsigned N_CH = 4;
    localparam int unsigned N_SW = 4;
    localparam int unsigned DEB  = 4;
    localparam int unsigned BH   = 8;
    localparam int unsigned PB   = 3;
    localparam int PERIOD        = 1 << PB;
    localparam int RAMP          = (1 << (PB + 1)) - 2;
    localparam int DMAX          = PERIOD - 1;

    logic              clk;
    logic              reset;
    logic [N_SW-1:0]   gpio_switch;
    logic [2*N_CH-1:0] mode;
    logic [N_CH-1:0]   gpio_led;
    logic [N_SW-1:0]   sw_clean;
    logic [N_SW-1:0]   sw_rise;

    int checks;
    int errors;

    logic [11:0] exp_q[$];

    gpio_led_ctrl #(
        .N_CH(N_CH), .N_SW(N_SW), .DEBOUNCE_CYCLES(DEB), .BLINK_HALF(BH), .PWM_BITS(PB)
    ) dut (
        .SYSTEMCLOCK(clk),
        .reset      (reset),
        .gpio_switch(gpio_switch),
        .mode       (mode),
        .gpio_led   (gpio_led),
        .sw_clean   (sw_clean),
        .sw_rise    (sw_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Duty during PWM period p: triangle 0..DMAX..1 repeating every RAMP periods.
    function automatic int breathe_duty(input int p);
        int q;
        q = p % RAMP;
        return (q <= DMAX) ? q : RAMP - q;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Reference model: n counts clock edges since the last reset edge.
    initial begin : model
        int n;
        int run[N_SW];
        logic [N_SW-1:0] s0, s1, clean, cprev, rise, c_old;
        logic [N_CH-1:0] led;
        n = 0; s0 = '0; s1 = '0; clean = '0; cprev = '0; rise = '0; led = '1;
        for (int j = 0; j < N_SW; j++) run[j] = 0;
        forever begin
            @(posedge clk);
            if (reset) begin
                n = 0; s0 = '0; s1 = '0; clean = '0; cprev = '0; rise = '0; led = '1;
                for (int j = 0; j < N_SW; j++) run[j] = 0;
            end else begin
                c_old = clean;
                for (int i = 0; i < N_CH; i++) begin
                    case (mode[2*i +: 2])
                        2'd0:    led[i] = c_old[i % N_SW];
                        2'd1:    led[i] = |c_old;
                        2'd2:    led[i] = (((n + 1) / BH) % 2) == 0;
                        default: led[i] = (n % PERIOD) < breathe_duty(n / PERIOD);
                    endcase
                end
                rise  = c_old & ~cprev;
                cprev = c_old;
                // Accept a level after DEB consecutive disagreeing samples.
                for (int j = 0; j < N_SW; j++) begin
                    if (s1[j] != c_old[j]) begin
                        run[j]++;
                        if (run[j] == DEB) begin
                            clean[j] = s1[j];
                            run[j]   = 0;
                        end
                    end else begin
                        run[j] = 0;
                    end
                end
                s1 = s0;
                s0 = gpio_switch;
                n++;
            end
            exp_q.push_back({led, clean, rise});
        end
    end

    initial begin : monitor
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gpio_led", gpio_led, e[11:8]);
                check("sw_clean", sw_clean, e[7:4]);
                check("sw_rise",  sw_rise,  e[3:0]);
            end
        end
    end

    initial begin : driver
        checks = 0;
        errors = 0;
        reset = 1'b1;
        gpio_switch = '0;
        mode = 8'($urandom);
        tick(3);
        reset = 1'b0;

        // All channels blinking, then a reset in the middle of a period.
        mode = 8'hAA;
        tick(21);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(20);

        // Direct mode: a short glitch, then a held press on switch 2.
        mode = 8'h00;
        gpio_switch = 4'b0100;
        tick(3);
        gpio_switch = 4'b0000;
        tick(10);
        gpio_switch = 4'b0100;
        tick(10);
        gpio_switch = 4'b0000;
        tick(12);

        // Channel 0 as OR of all switches, driven by switch 3 only.
        mode = 8'h01;
        gpio_switch = 4'b1000;
        tick(12);
        gpio_switch = 4'b0000;
        tick(12);

        // Channel 1 breathing over more than two full ramps.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        mode = 8'b0000_1100;
        tick(PERIOD * RAMP * 2 + 20);

        // Channel 3 leaves BLINK mid-period while switch 3 is held high.
        mode = 8'hAA;
        gpio_switch = 4'b1000;
        tick(13);
        mode = 8'h2A;
        tick(20);

        // Random switches, modes and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) gpio_switch = 4'($urandom);
            if ($urandom_range(0, 40) == 0) mode = 8'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        reset = 1'b0;
        tick(2);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_led_ctrl.md
# gpio_led_ctrl

Parametrised front-panel controller: drives N_CH LEDs from N_SW debounced switches, a shared blink timer and a breathing PWM generator. Each LED channel has a runtime-selectable mode. Sits at top level between the board GPIO pins and the rest of the design, and also exports clean switch levels and rising-edge pulses for other logic.

## Interface

- N_CH, 4: number of LED channels.
- N_SW, 4: number of switch inputs.
- DEBOUNCE_CYCLES, 500_000: consecutive stable cycles required before a switch level is accepted; ≥1.
- BLINK_HALF, 50_000_000: blink half-period in clock cycles; ≥2.
- PWM_BITS, 8: PWM counter and duty width; ≥2.
- SYSTEMCLOCK  in  1  clock.
- reset  in  1  synchronous, active-high.
- gpio_switch  in  N_SW  raw asynchronous switch pins.
- mode  in  2*N_CH  per-channel mode; channel i uses mode[2i+1:2i].
- gpio_led  out  N_CH  registered LED drive.
- sw_clean  out  N_SW  debounced switch levels.
- sw_rise  out  N_SW  one-cycle pulse on each debounced 0→1 transition.

## Operation

- Every switch passes through a 2-flop synchroniser, then a debouncer. Each debouncer holds a stable-count; it clears whenever the synchronised input equals sw_clean. When the count reaches DEBOUNCE_CYCLES-1 while the input still differs, sw_clean takes the input value and the count clears.
- sw_rise[j] is high for exactly one cycle, the cycle after sw_clean[j] goes 0→1.
- Blink timer: counter 0..BLINK_HALF-1. On the wrap cycle it returns to 0 and blink_phase toggles.
- Breathing PWM: pwm_cnt is free-running PWM_BITS wide. On each pwm_cnt wrap (all-ones→0), duty steps by 1 in the current direction. At all-ones the direction becomes down; at 0 it becomes up. Neither endpoint is repeated. pwm_out = (pwm_cnt < duty).
- Channel modes:
  - 0 DIRECT: sw_clean[i mod N_SW].
  - 1 ANY: OR of all sw_clean.
  - 2 BLINK: blink_phase.
  - 3 BREATHE: pwm_out.
- Reset values:
  - gpio_led all 1s, as a lamp test.
  - sw_clean 0, sw_rise 0.
  - Synchronisers, debounce counts, blink counter and pwm_cnt 0.
  - blink_phase 1, duty 0, direction up.
- A reset asserted mid-operation overrides everything in that cycle. The next cycle shows the reset values.

## Timing

- Pin → sw_clean latency: 2 sync cycles + DEBOUNCE_CYCLES. An input glitch shorter than DEBOUNCE_CYCLES produces no change.
- sw_clean → gpio_led (DIRECT/ANY): 1 cycle.
- Mode change takes effect on gpio_led 1 cycle after mode is sampled. No other state is disturbed by a mode change.
- Blink: gpio_led in BLINK toggles every BLINK_HALF cycles.
- Breathe: a full ramp (0 to max to 0) takes (2^(PWM_BITS+1)-2) PWM periods of 2^PWM_BITS cycles.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Structure

- Package gpio_led_pkg holds the mode encodings (MODE_DIRECT=2'd0, MODE_ANY=2'd1, MODE_BLINK=2'd2, MODE_BREATHE=2'd3) and the counter-width helper function (clog2).
- Sub-module sw_debounce covers one switch: synchroniser, stable-count, clean level and rise pulse. It is parametrised by DEBOUNCE_CYCLES and instantiated N_SW times in a generate loop.
- Blink timer, PWM generator and per-channel mode mux live in gpio_led_ctrl.

## Test plan

Bench parameters: N_CH=4, N_SW=4, DEBOUNCE_CYCLES=4, BLINK_HALF=8, PWM_BITS=3.

- Reset: hold reset 3 cycles with any mode → gpio_led=4'b1111, sw_clean=0, sw_rise=0 on the cycle after release. Assert reset mid-blink → same values the next cycle.
- Debounce: all channels DIRECT. Raise switch 2 for 3 cycles, then drop → no change. Raise for 10 cycles → sw_clean[2]=1 exactly 6 cycles after the pin edge, sw_rise[2] high for 1 cycle, gpio_led[2]=1 one cycle later.
- ANY: channel 0 in ANY mode, only switch 3 stable high → gpio_led[0]=1. Release switch 3 → gpio_led[0]=0 after 7 cycles.
- BLINK: all channels BLINK after reset → gpio_led toggles every 8 cycles, first falling edge 8 cycles after reset release.
- BREATHE: channel 1 in BREATHE → high-count per 8-cycle window follows 0,1,…,7,6,…,1,0,1. The sequence never repeats 7 or 0 back-to-back.
- Mode switch: change channel 3 from BLINK to DIRECT mid-period with switch 3 high → gpio_led[3]=1 one cycle later. Blink phase on the other channels is undisturbed.
